// File: rtl/shifter_multicycle.sv
// Iterative multi-cycle shifter: SLL/SRL/SRA/ROL, at most STEP bits per clock,
// driven through a start/busy/done handshake with a registered result.
module shifter_multicycle #(
  parameter int WIDTH = 32,
  parameter int STEP  = 8,
  localparam int AW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] In,
  input  logic [WIDTH-1:0] Sel,
  input  logic [1:0]       Mode,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Out
);

  // A STEP of WIDTH does not fit in AW bits; WIDTH-1 covers every legal amount.
  localparam int STEP_EFF = (STEP >= WIDTH) ? (WIDTH - 1) : STEP;
  localparam logic [AW-1:0] STEP_C = AW'(STEP_EFF);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [AW-1:0]    amt_q, amt_d;
  logic [1:0]       mode_q, mode_d;
  logic [WIDTH-1:0] out_q, out_d;

  logic [AW-1:0]      step_amt;
  logic [2*WIDTH-1:0] rot_wide;
  logic [WIDTH-1:0]   shifted;
  logic               sel_unused;

  // Only the low AW bits of the amount matter; larger amounts wrap.
  assign sel_unused = ^Sel[WIDTH-1:AW];

  always_comb begin
    step_amt = (amt_q < STEP_C) ? amt_q : STEP_C;
    rot_wide = {data_q, data_q} << step_amt;
    shifted  = data_q;
    case (mode_q)
      2'b00:   shifted = data_q << step_amt;
      2'b01:   shifted = data_q >> step_amt;
      2'b10:   shifted = $signed(data_q) >>> step_amt;
      default: shifted = rot_wide[2*WIDTH-1:WIDTH];
    endcase
  end

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    amt_d   = amt_q;
    mode_d  = mode_q;
    out_d   = out_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          data_d = In;
          amt_d  = Sel[AW-1:0];
          mode_d = Mode;
          if (Sel[AW-1:0] == '0) begin
            state_d = ST_DONE;
            out_d   = In;
          end else begin
            state_d = ST_SHIFT;
          end
        end
      end
      ST_SHIFT: begin
        data_d = shifted;
        amt_d  = amt_q - step_amt;
        if (amt_q == step_amt) begin
          state_d = ST_DONE;
          out_d   = shifted;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      data_q  <= '0;
      amt_q   <= '0;
      mode_q  <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      amt_q   <= amt_d;
      mode_q  <= mode_d;
      out_q   <= out_d;
    end
  end

  assign busy = (state_q != ST_IDLE);
  assign done = (state_q == ST_DONE);
  assign Out  = out_q;

endmodule

// File: tb/tb_shifter_multicycle.sv
// Directed bench for shifter_multicycle (WIDTH=32, STEP=8): vector table plus
// hand-written sequences for start-while-busy and mid-operation reset.
module tb_shifter_multicycle;

  localparam int WIDTH = 32;
  localparam int STEP  = 8;
  localparam int MAX_WAIT = 40;

  logic             clk;
  logic             reset;
  logic             start;
  logic [WIDTH-1:0] In;
  logic [WIDTH-1:0] Sel;
  logic [1:0]       Mode;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] Out;

  int errors;
  int checks;

  shifter_multicycle #(.WIDTH(WIDTH), .STEP(STEP)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .In    (In),
    .Sel   (Sel),
    .Mode  (Mode),
    .busy  (busy),
    .done  (done),
    .Out   (Out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  mode;
    logic [31:0] in_val;
    logic [31:0] sel_val;
    logic [31:0] exp_out;
    int          exp_lat;
  } vec_t;

  localparam int NVEC = 15;
  vec_t vecs [NVEC];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Launches one operation, then scrambles the inputs to prove they were captured.
  task automatic run_op(input string tag, input logic [1:0] m, input logic [31:0] a,
                        input logic [31:0] s, input logic [31:0] exp_out, input int exp_lat);
    int cyc;
    @(negedge clk);
    start = 1'b1; In = a; Sel = s; Mode = m;
    @(negedge clk);
    start = 1'b0; In = $urandom; Sel = $urandom; Mode = ~m;
    cyc = 1;
    check({tag, " busy_c1"}, {31'b0, busy}, 32'd1);
    while (!done && cyc < MAX_WAIT) begin
      @(negedge clk);
      cyc++;
    end
    check({tag, " done_cycle"}, cyc, exp_lat);
    check({tag, " out"}, Out, exp_out);
    @(negedge clk);
    check({tag, " done_pulse_end"}, {31'b0, done}, 32'd0);
    check({tag, " idle_after"}, {31'b0, busy}, 32'd0);
    check({tag, " out_held"}, Out, exp_out);
    $display("op %s mode=%0d in=0x%08h sel=0x%08h -> out=0x%08h done_cycle=%0d",
             tag, m, a, s, Out, cyc);
  endtask

  initial begin
    int cyc;
    errors = 0;
    checks = 0;
    reset = 1'b1; start = 1'b0; In = '0; Sel = '0; Mode = 2'b00;

    vecs[0]  = '{2'b00, 32'h0000_0001, 32'd1,          32'h0000_0002, 2};
    vecs[1]  = '{2'b00, 32'hFFFF_FFFF, 32'd3,          32'hFFFF_FFF8, 2};
    vecs[2]  = '{2'b00, 32'h7FFF_FFFF, 32'd0,          32'h7FFF_FFFF, 1};
    vecs[3]  = '{2'b00, 32'h0000_0003, 32'd1,          32'h0000_0006, 2};
    vecs[4]  = '{2'b10, 32'h8000_0000, 32'd31,         32'hFFFF_FFFF, 5};
    vecs[5]  = '{2'b01, 32'h8000_0000, 32'd31,         32'h0000_0001, 5};
    vecs[6]  = '{2'b11, 32'h8000_0001, 32'd20,         32'h0018_0000, 4};
    vecs[7]  = '{2'b00, 32'h0000_0001, 32'h0000_0021, 32'h0000_0002, 2};
    vecs[8]  = '{2'b10, 32'h8000_0000, 32'd8,          32'hFF80_0000, 2};
    vecs[9]  = '{2'b10, 32'h7F00_0000, 32'd12,         32'h0007_F000, 3};
    vecs[10] = '{2'b11, 32'h1234_5678, 32'd8,          32'h3456_7812, 2};
    vecs[11] = '{2'b01, 32'hF000_0000, 32'd16,         32'h0000_F000, 3};
    vecs[12] = '{2'b11, 32'hDEAD_BEEF, 32'd0,          32'hDEAD_BEEF, 1};
    vecs[13] = '{2'b11, 32'h8000_0000, 32'd31,         32'h4000_0000, 5};
    vecs[14] = '{2'b00, 32'h0000_0001, 32'hFFFF_FFE0, 32'h0000_0001, 1};

    // Reset state and quiet idle.
    repeat (2) begin
      @(negedge clk);
      check("reset out", Out, 32'h0);
      check("reset done", {31'b0, done}, 32'd0);
      check("reset busy", {31'b0, busy}, 32'd0);
    end
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("idle out", Out, 32'h0);
      check("idle done", {31'b0, done}, 32'd0);
      check("idle busy", {31'b0, busy}, 32'd0);
    end
    $display("reset/idle sequence checked");

    for (int i = 0; i < NVEC; i++) begin
      run_op($sformatf("vec%0d", i), vecs[i].mode, vecs[i].in_val, vecs[i].sel_val,
             vecs[i].exp_out, vecs[i].exp_lat);
    end

    // start pulsed during SHIFT must be neither accepted nor queued.
    @(negedge clk);
    start = 1'b1; In = 32'h0000_000F; Sel = 32'd24; Mode = 2'b00;
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    @(negedge clk);
    cyc = 2;
    start = 1'b1; In = 32'h0; Sel = 32'h0;
    @(negedge clk);
    cyc = 3;
    start = 1'b0;
    while (!done && cyc < MAX_WAIT) begin
      @(negedge clk);
      cyc++;
    end
    check("busy_start done_cycle", cyc, 4);
    check("busy_start out", Out, 32'h0F00_0000);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("busy_start no_queue done", {31'b0, done}, 32'd0);
      check("busy_start no_queue busy", {31'b0, busy}, 32'd0);
    end
    $display("op busy_start -> out=0x%08h done_cycle=%0d", Out, cyc);

    // Reset in the middle of a shift aborts it without a done pulse.
    @(negedge clk);
    start = 1'b1; In = 32'h0000_000F; Sel = 32'd24; Mode = 2'b00;
    @(negedge clk);
    start = 1'b0;
    check("abort busy_c1", {31'b0, busy}, 32'd1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort out", Out, 32'h0);
    check("abort busy", {31'b0, busy}, 32'd0);
    check("abort done", {31'b0, done}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("abort no_done", {31'b0, done}, 32'd0);
      check("abort stays_idle", {31'b0, busy}, 32'd0);
    end
    $display("op abort -> out=0x%08h busy=%0d", Out, busy);
    run_op("after_abort", 2'b00, 32'h1, 32'd1, 32'h0000_0002, 2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/shifter_multicycle.md
Name: shifter_multicycle

Overview:
Parametrised, iterative multi-cycle shifter. It is the successor to the combinational 32-bit left shifter in the datapath component library. It supports logical left, logical right, arithmetic right and rotate left. Each cycle it shifts by at most STEP bits, which trades latency for area. The ALU control FSM drives it through a start/busy/done handshake.

Parameters:
WIDTH, 32, data width in bits (power of two, >= 2)
STEP, 8, maximum bits shifted per clock cycle (power of two, 1..WIDTH)
AW, $clog2(WIDTH), localparam: width of the effective shift amount

Ports:
clk    input   1      clock; all state updates on the rising edge
reset  input   1      synchronous, active-high reset
start  input   1      request; sampled only in IDLE
In     input   WIDTH  operand to shift; captured on the accepted start
Sel    input   WIDTH  shift amount; only Sel[AW-1:0] is used, the upper bits are ignored
Mode   input   2      00 SLL, 01 SRL, 10 SRA, 11 ROL; captured on the accepted start
busy   output  1      high whenever state != IDLE
done   output  1      one-cycle pulse; Out is valid in that cycle
Out    output  WIDTH  registered result; held until the next done

Behaviour:
- Reset: synchronous and active-high. Forces state=IDLE, busy=0, done=0, Out=0, and clears the internal data and count registers.
- Reset asserted mid-operation aborts the operation. No done pulse is produced.
- FSM has three states: IDLE, SHIFT, DONE.
- IDLE:
  - When start=1, capture data<=In, amt<=Sel[AW-1:0], mode<=Mode.
  - Next state is DONE if amt==0, otherwise SHIFT.
- SHIFT (once per cycle):
  - s = min(amt, STEP).
  - data <= data shifted by s according to mode.
  - amt <= amt - s.
  - When the new amt==0, next state is DONE.
- DONE:
  - done=1 for exactly one cycle.
  - Out equals the final data value, loaded on the edge that enters DONE.
  - Next state is IDLE unconditionally.
- Latency: let start be sampled at the end of cycle 0, and N = ceil(amt/STEP).
  - The FSM is in SHIFT during cycles 1..N.
  - done is high in cycle N+1. For amt==0, done is high in cycle 1.
- Throughput: one operation per N+2 cycles. No back-to-back acceptance occurs in the DONE cycle.
- start is ignored while busy=1. It is neither queued nor able to corrupt the operation in flight.
- In, Sel and Mode changes after capture have no effect on the operation in flight.
- Mode semantics:
  - SLL fills with zeros.
  - SRL fills with zeros.
  - SRA fills with the captured In[WIDTH-1] on every step.
  - ROL is a circular left rotate, so bits shifted out of the MSB re-enter at the LSB.
- Amounts >= WIDTH wrap modulo WIDTH, because only Sel[AW-1:0] is used.
- Out holds its last value through IDLE and SHIFT. It changes only on the edge that enters DONE, or on reset.

Test Plan:
Every scenario below uses WIDTH=32 and STEP=8.

1. Assert reset for 2 cycles -> Out=0x00000000, done=0, busy=0. Then release reset and keep start=0 for 5 cycles -> all three outputs unchanged.
2. SLL, In=0x00000001, Sel=1 -> busy=1 in cycle 1, done=1 in cycle 2, Out=0x00000002. Next, SLL, In=0xFFFFFFFF, Sel=3 -> Out=0xFFFFFFF8.
3. SLL, In=0x7FFFFFFF, Sel=0 -> done=1 in cycle 1, Out=0x7FFFFFFF. Next, SLL, In=0x00000003, Sel=1 -> Out=0x00000006.
4. SRA, In=0x80000000, Sel=31 -> N=4, done=1 in cycle 5, Out=0xFFFFFFFF. Next, SRL with the same operands -> Out=0x00000001.
5. ROL, In=0x80000001, Sel=20 -> done=1 in cycle 4, Out=0x00180000. Next, SLL, In=0x00000001, Sel=0x00000021 -> amount wraps to 1, Out=0x00000002.
6. Start SLL, In=0x0000000F, Sel=24 -> during SHIFT, pulse start with In=0, Sel=0 -> ignored, final Out=0x0F000000. Start SLL, Sel=24 again and assert reset in cycle 2 -> no done, Out=0, busy=0. Then start SLL, In=1, Sel=1 -> Out=0x00000002.
